// File: rtl/msx_mouse_pkg.sv
// Shared types and helpers for the MSX mouse port: read phase encoding and
// saturation to the accumulator range.
package msx_mouse_pkg;

  localparam int ACC_W   = 8;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  // Clamp a signed value to the w-bit two's-complement range; ~hi equals -hi-1.
  function automatic logic signed [15:0] sat(input logic signed [15:0] v, input int w);
    logic signed [15:0] hi;
    logic signed [15:0] lo;
    hi = 16'((1 << (w - 1)) - 1);
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/msx_mouse_acc.sv
// One axis of motion: saturating accumulator plus read snapshot.
// MSX_MOUSE_HALFSPEED_EN halves each delta, carrying the dropped LSB forward.
module msx_mouse_acc
  import msx_mouse_pkg::*;
#(
  parameter int ACC_W  = msx_mouse_pkg::ACC_W,
  parameter bit NEGATE = 1'b0
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             add,
  input  logic             take,
  input  logic [8:0]       delta,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] snap
);

  localparam int SUM_W = ACC_W + 3;

  logic signed [SUM_W-1:0] d_ext;
  logic signed [SUM_W-1:0] d_scaled;
  logic signed [SUM_W-1:0] acc_sum;
  logic signed [SUM_W-1:0] add_sum;
  logic [ACC_W-1:0]        acc_next;
  logic [ACC_W-1:0]        delta_only;

  always_comb begin
    d_ext = {{(SUM_W-9){delta[8]}}, delta};
    if (NEGATE) d_ext = -d_ext;
  end

`ifdef MSX_MOUSE_HALFSPEED_EN
  logic                    rem;
  logic signed [SUM_W-1:0] d_total;

  assign d_total  = d_ext + $signed({{(SUM_W-1){1'b0}}, rem});
  assign d_scaled = d_total >>> 1;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)   rem <= 1'b0;
    else if (clear) rem <= 1'b0;
    else if (add)   rem <= d_total[0];
  end
`else
  assign d_scaled = d_ext;
`endif

  assign acc_sum = {{3{acc[ACC_W-1]}}, acc} + d_scaled;
  assign add_sum = d_scaled;

  always_comb begin
    acc_next   = ACC_W'(sat({{(16-SUM_W){acc_sum[SUM_W-1]}}, acc_sum}, ACC_W));
    delta_only = ACC_W'(sat({{(16-SUM_W){add_sum[SUM_W-1]}}, add_sum}, ACC_W));
  end

  // On a take the snapshot is subtracted at once, so only new motion remains.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      snap <= '0;
    end else if (clear) begin
      acc  <= '0;
      snap <= '0;
    end else if (take) begin
      snap <= acc;
      acc  <= add ? delta_only : '0;
    end else if (add) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/msx_mouse_port.sv
// Host mouse packets to MSX joystick-port mouse nibbles, four per read cycle.
// Optional build macro: MSX_MOUSE_HALFSPEED_EN (halves motion per axis).
//
// state | meaning
// P0    | next strobe edge snapshots motion, serves X[7:4]
// P1    | next edge serves X[3:0]
// P2    | next edge serves Y[7:4]
// P3    | next edge serves Y[3:0], back to P0
module msx_mouse_port
  import msx_mouse_pkg::*;
#(
  parameter int TIMEOUT = 100000,
  parameter int ACC_W   = msx_mouse_pkg::ACC_W
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [8:0] mouse_x,
  input  logic [8:0] mouse_y,
  input  logic [7:0] mouse_flags,
  input  logic       mouse_strobe,
  input  logic       joy_active,
  input  logic       msx_str,
  output logic       mouse_en,
  output logic [5:0] port_n
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  phase_t           phase;
  logic [CNT_W-1:0] cnt;
  logic             s1, s2, s3;
  logic             str_edge;
  logic             acc_clear;
  logic             take;
  logic [ACC_W-1:0] acc_x, snap_x, acc_y, snap_y;
  logic             unused_bits;

  assign str_edge  = s2 ^ s3;
  // The enabling packet itself must survive, so clear only when staying disabled.
  assign acc_clear = ~mouse_en & ~mouse_strobe;
  assign take      = mouse_en & str_edge & (phase == P0);
  assign unused_bits = ^{mouse_flags[7:2], snap_x[ACC_W-1:4], acc_y};

  msx_mouse_acc #(.ACC_W(ACC_W), .NEGATE(1'b1)) u_acc_x (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear   (acc_clear),
    .add     (mouse_strobe),
    .take    (take),
    .delta   (mouse_x),
    .acc     (acc_x),
    .snap    (snap_x)
  );

  msx_mouse_acc #(.ACC_W(ACC_W), .NEGATE(1'b0)) u_acc_y (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear   (acc_clear),
    .add     (mouse_strobe),
    .take    (take),
    .delta   (mouse_y),
    .acc     (acc_y),
    .snap    (snap_y)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      mouse_en <= 1'b0;
      phase    <= P0;
      cnt      <= '0;
      port_n   <= 6'h3F;
    end else begin
      s1 <= msx_str;
      s2 <= s1;
      s3 <= s2;

      if (mouse_strobe)    mouse_en <= 1'b1;
      else if (joy_active) mouse_en <= 1'b0;

      if (!mouse_en) begin
        phase  <= P0;
        cnt    <= '0;
        port_n <= 6'h3F;
      end else begin
        port_n[5:4] <= ~mouse_flags[1:0];
        if (str_edge) begin
          cnt <= CNT_W'(TIMEOUT);
          case (phase)
            P0: begin port_n[3:0] <= acc_x[ACC_W-1:ACC_W-4];  phase <= P1; end
            P1: begin port_n[3:0] <= snap_x[3:0];             phase <= P2; end
            P2: begin port_n[3:0] <= snap_y[ACC_W-1:ACC_W-4]; phase <= P3; end
            P3: begin port_n[3:0] <= snap_y[3:0];             phase <= P0; end
            default: phase <= P0;
          endcase
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) phase <= P0;
        end
      end
    end
  end

endmodule
